crc_serial: RTL and testbench

CRC_SERIAL -- requirements
Module: crc_serial

---
 rtl/crc_pkg.sv | 29 ++
 rtl/crc_step.sv | 31 +++
 rtl/crc_serial.sv | 173 +++++++++++++++++
 tb/tb_crc_serial.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : crc_pkg                                                      |
// | Description : Shared types and constants for the serial CRC block: the     |
// |               controller state encoding and the Gen2 CRC-5 / CRC-16        |
// |               polynomial, preset and good-frame residue values.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package crc_pkg;

  // Controller states; explicit 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_APPEND = 2'd2
  } crc_state_e;

  // Gen2 CRC-5
  localparam logic [4:0]  CRC5_POLY     = 5'b01001;
  localparam logic [4:0]  CRC5_PRESET   = 5'b01001;
  localparam logic [4:0]  CRC5_RESIDUE  = 5'b00000;

  // Gen2 CRC-16 (CCITT polynomial, inverted on transmit)
  localparam logic [15:0] CRC16_POLY    = 16'h1021;
  localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;

endpackage
`default_nettype wire

// File: rtl/crc_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : crc_step                                                     |
// | Description : Combinational single-bit CRC update, MSB-first Galois form.  |
// |               The message bit is folded into the register MSB and the      |
// |               polynomial is XORed in when that feedback bit is set.        |
// | Ports       : crc_in  [WIDTH] current register                             |
// |               bit_in  [1]     message bit                                  |
// |               crc_out [WIDTH] register after absorbing bit_in              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module crc_step
  import crc_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = CRC16_POLY
) (
  input  logic [WIDTH-1:0] crc_in,
  input  logic             bit_in,
  output logic [WIDTH-1:0] crc_out
);

  logic fb;

  always_comb begin
    fb      = bit_in ^ crc_in[WIDTH-1];
    crc_out = {crc_in[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

endmodule
`default_nettype wire

// File: rtl/crc_serial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : crc_serial                                                   |
// | Description : Bit-serial CRC generator / checker. A frame opens on start.  |
// |               Payload bits pass through a one-deep registered output slot  |
// |               while updating the CRC. In generate mode the CRC is appended |
// |               MSB-first (optionally inverted) after the last payload bit;  |
// |               in check mode the frame ends with the last payload bit and   |
// |               chk reports whether the register equals the residue.         |
// | Ports       : clk, rst                   clock, sync active-high reset     |
// |               start, gen                 frame open pulse, mode select     |
// |               in_dat/in_vld/in_last/in_rdy   serial payload input          |
// |               out_dat/out_vld/out_last/out_rdy registered serial output    |
// |               crc [WIDTH]                current CRC register              |
// |               chk, chk_vld               residue match, result valid       |
// |               busy                       frame in progress                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module crc_serial
  import crc_pkg::*;
#(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] POLY       = CRC16_POLY,
  parameter logic [WIDTH-1:0] PRESET     = CRC16_PRESET,
  parameter logic [WIDTH-1:0] RESIDUE    = CRC16_RESIDUE,
  parameter logic             INVERT_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             gen,
  input  logic             in_dat,
  input  logic             in_vld,
  input  logic             in_last,
  output logic             in_rdy,
  output logic             out_dat,
  output logic             out_vld,
  output logic             out_last,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] crc,
  output logic             chk,
  output logic             chk_vld,
  output logic             busy
);

  localparam int               IDX_W   = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

  crc_state_e       state_q,    state_d;
  logic [WIDTH-1:0] crc_q,      crc_d;
  logic             out_dat_q,  out_dat_d;
  logic             out_vld_q,  out_vld_d;
  logic             out_last_q, out_last_d;
  logic             chk_vld_q,  chk_vld_d;
  logic [IDX_W-1:0] idx_q,      idx_d;
  logic             gen_q,      gen_d;

  logic             slot_free;
  logic             accept;
  logic [WIDTH-1:0] crc_next;

  crc_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_step (
    .crc_in  (crc_q),
    .bit_in  (in_dat),
    .crc_out (crc_next)
  );

  // The output slot can take a new bit when empty or being drained this cycle,
  // which is what keeps the stream loss-free under backpressure.
  assign slot_free = !out_vld_q || out_rdy;
  assign in_rdy    = (state_q == ST_DATA) && slot_free;
  assign accept    = in_vld && in_rdy;

  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    out_dat_d  = out_dat_q;
    out_vld_d  = out_vld_q;
    out_last_d = out_last_q;
    chk_vld_d  = chk_vld_q;
    idx_d      = idx_q;
    gen_d      = gen_q;

    // Drain the slot; a load below overrides this in the same cycle.
    if (out_vld_q && out_rdy) begin
      out_vld_d  = 1'b0;
      out_last_d = 1'b0;
    end

    if (start) begin
      // Opens a frame from any state, discarding whatever was in flight.
      state_d    = ST_DATA;
      crc_d      = PRESET;
      out_vld_d  = 1'b0;
      out_last_d = 1'b0;
      chk_vld_d  = 1'b0;
      idx_d      = '0;
      gen_d      = gen;
    end else begin
      case (state_q)
        ST_DATA: begin
          if (accept) begin
            crc_d      = crc_next;
            out_dat_d  = in_dat;
            out_vld_d  = 1'b1;
            out_last_d = 1'b0;
            if (in_last) begin
              if (gen_q) begin
                state_d = ST_APPEND;
                idx_d   = IDX_TOP;
              end else begin
                state_d   = ST_IDLE;
                chk_vld_d = 1'b1;
              end
            end
          end
        end
        ST_APPEND: begin
          // CRC register is frozen here; bits are read out by index.
          if (slot_free) begin
            out_dat_d  = crc_q[idx_q] ^ INVERT_OUT;
            out_vld_d  = 1'b1;
            out_last_d = (idx_q == '0);
            if (idx_q == '0) begin
              state_d   = ST_IDLE;
              chk_vld_d = 1'b1;
            end else begin
              idx_d = idx_q - 1'b1;
            end
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      crc_q      <= PRESET;
      out_dat_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      chk_vld_q  <= 1'b0;
      idx_q      <= '0;
      gen_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      out_dat_q  <= out_dat_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
      chk_vld_q  <= chk_vld_d;
      idx_q      <= idx_d;
      gen_q      <= gen_d;
    end
  end

  assign out_dat  = out_dat_q;
  assign out_vld  = out_vld_q;
  assign out_last = out_last_q;
  assign crc      = crc_q;
  assign chk_vld  = chk_vld_q;
  assign chk      = chk_vld_q && (crc_q == RESIDUE);
  assign busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_crc_serial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_crc_serial                                                |
// | Description : Self-checking bench for crc_serial. A CRC-16 and a CRC-5     |
// |               instance share one stimulus bus, gated by sel5. Expected     |
// |               CRCs come from polynomial long division over a bit array.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_crc_serial;

  logic clk = 1'b0;
  logic rst, start, gen, in_dat, in_vld, in_last, out_rdy, sel5;

  logic        in_rdy16, out_dat16, out_vld16, out_last16, chk16, chk_vld16, busy16;
  logic [15:0] crc16;
  logic        in_rdy5, out_dat5, out_vld5, out_last5, chk5, chk_vld5, busy5;
  logic [4:0]  crc5;

  logic        in_rdy_o, out_dat_o, out_vld_o, out_last_o, chk_o, chk_vld_o, busy_o;
  logic [31:0] crc_o;

  int n_checks = 0;
  int n_fail   = 0;
  int bp_viol;

  bit tx_q[$];
  bit rx_q[$];
  bit rxl_q[$];

  always #5 clk = ~clk;

  crc_serial u_dut16 (
    .clk(clk), .rst(rst), .start(start & ~sel5), .gen(gen),
    .in_dat(in_dat), .in_vld(in_vld & ~sel5), .in_last(in_last), .in_rdy(in_rdy16),
    .out_dat(out_dat16), .out_vld(out_vld16), .out_last(out_last16), .out_rdy(out_rdy),
    .crc(crc16), .chk(chk16), .chk_vld(chk_vld16), .busy(busy16)
  );

  crc_serial #(
    .WIDTH(5), .POLY(5'b01001), .PRESET(5'b01001), .RESIDUE(5'b00000), .INVERT_OUT(1'b0)
  ) u_dut5 (
    .clk(clk), .rst(rst), .start(start & sel5), .gen(gen),
    .in_dat(in_dat), .in_vld(in_vld & sel5), .in_last(in_last), .in_rdy(in_rdy5),
    .out_dat(out_dat5), .out_vld(out_vld5), .out_last(out_last5), .out_rdy(out_rdy),
    .crc(crc5), .chk(chk5), .chk_vld(chk_vld5), .busy(busy5)
  );

  assign in_rdy_o   = sel5 ? in_rdy5   : in_rdy16;
  assign out_dat_o  = sel5 ? out_dat5  : out_dat16;
  assign out_vld_o  = sel5 ? out_vld5  : out_vld16;
  assign out_last_o = sel5 ? out_last5 : out_last16;
  assign chk_o      = sel5 ? chk5      : chk16;
  assign chk_vld_o  = sel5 ? chk_vld5  : chk_vld16;
  assign busy_o     = sel5 ? busy5     : busy16;
  assign crc_o      = sel5 ? {27'd0, crc5} : {16'd0, crc16};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Parameters of the currently selected instance.
  function automatic int cur_w();
    return sel5 ? 5 : 16;
  endfunction
  function automatic logic [31:0] cur_poly();
    return sel5 ? 32'h09 : 32'h1021;
  endfunction
  function automatic logic [31:0] cur_preset();
    return sel5 ? 32'h09 : 32'hFFFF;
  endfunction
  function automatic logic [31:0] cur_res();
    return sel5 ? 32'h00 : 32'h1D0F;
  endfunction
  function automatic bit cur_inv();
    return sel5 ? 1'b0 : 1'b1;
  endfunction

  // CRC as the remainder of (preset*x^n + M(x)*x^w) mod (x^w + poly),
  // done by long division over an array ordered highest degree first.
  function automatic logic [31:0] ref_crc(input bit msg[$], input int w,
                                          input logic [31:0] poly, input logic [31:0] preset);
    bit a[];
    int n;
    logic [31:0] r;
    n = msg.size();
    a = new[n + w];
    for (int i = 0; i < n + w; i++) a[i] = (i < n) ? msg[i] : 1'b0;
    for (int k = 0; k < w; k++) a[w-1-k] ^= preset[k];
    for (int i = 0; i < n; i++) begin
      if (a[i]) begin
        a[i] = 1'b0;
        for (int k = 0; k < w; k++) a[i+w-k] ^= poly[k];
      end
    end
    r = '0;
    for (int k = 0; k < w; k++) r[k] = a[n+w-1-k];
    return r;
  endfunction

  task automatic do_start(input bit g);
    @(negedge clk);
    start = 1'b1; gen = g; in_vld = 1'b0; in_last = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_frame(input bit g, input bit bp, input int exp_n, output bit tout);
    int idx = 0;
    int cyc = 0;
    rx_q.delete();
    rxl_q.delete();
    bp_viol = 0;
    do_start(g);
    while (rx_q.size() < exp_n && cyc < 8 * exp_n + 50) begin
      @(negedge clk);
      out_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx < tx_q.size()) begin
        in_vld = 1'b1; in_dat = tx_q[idx]; in_last = (idx == tx_q.size() - 1);
      end else begin
        in_vld = 1'b0; in_dat = 1'b0; in_last = 1'b0;
      end
      #1;
      if (in_rdy_o && out_vld_o && !out_rdy) bp_viol++;
      if (in_vld && in_rdy_o) idx++;
      if (out_vld_o && out_rdy) begin
        rx_q.push_back(out_dat_o);
        rxl_q.push_back(out_last_o);
      end
      cyc++;
    end
    tout = (rx_q.size() < exp_n);
    in_vld = 1'b0; in_last = 1'b0; out_rdy = 1'b1;
  endtask

  // Runs tx_q as one frame on the selected instance and checks the stream,
  // the out_last placement, the final register and the check flags.
  task automatic frame_check(input string tag, input bit g, input bit bp);
    bit exp_q[$];
    logic [31:0] crc_m;
    int w, nbad, nlast;
    bit tout;
    w = cur_w();
    crc_m = ref_crc(tx_q, w, cur_poly(), cur_preset());
    exp_q = tx_q;
    if (g) for (int k = w - 1; k >= 0; k--) exp_q.push_back(crc_m[k] ^ cur_inv());
    run_frame(g, bp, exp_q.size(), tout);
    check_val({tag, "_timeout"}, 32'(tout), 32'd0);
    check_val({tag, "_len"}, rx_q.size(), exp_q.size());
    nbad = 0; nlast = 0;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      if (rx_q[i] != exp_q[i]) nbad++;
      if (rxl_q[i] != (g && i == exp_q.size() - 1)) nlast++;
    end
    check_val({tag, "_bits_bad"}, nbad, 0);
    check_val({tag, "_last_bad"}, nlast, 0);
    check_val({tag, "_bp_rdy"}, bp_viol, 0);
    @(negedge clk); #1;
    check_val({tag, "_crc"}, crc_o, crc_m);
    check_val({tag, "_chk_vld"}, 32'(chk_vld_o), 32'd1);
    check_val({tag, "_chk"}, 32'(chk_o), 32'(crc_m == cur_res()));
    check_val({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saved_q[$];
    logic [31:0] app;
    string s;
    bit tout;
    int nobs, nbad_out, n;
    logic [31:0] m;

    rst = 1'b1; start = 1'b0; gen = 1'b0; in_dat = 1'b0; in_vld = 1'b0;
    in_last = 1'b0; out_rdy = 1'b1; sel5 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst16_crc", crc_o, 32'hFFFF);
    check_val("rst16_vld", 32'(out_vld_o), 0);
    check_val("rst16_busy", 32'(busy_o), 0);
    check_val("rst16_rdy", 32'(in_rdy_o), 0);
    check_val("rst16_chkv", 32'(chk_vld_o), 0);
    sel5 = 1'b1; #1;
    check_val("rst5_crc", crc_o, 32'h09);

    // CRC-5 generate over a single '1'.
    tx_q = '{1'b1};
    frame_check("c5_gen", 1'b1, 1'b0);
    app = 0;
    foreach (rx_q[i]) app = {app[30:0], 1'(rx_q[i])};
    check_val("c5_gen_stream", app, 32'b111011);
    check_val("c5_gen_crc_const", crc_o, 32'b11011);

    // CRC-5 check over the generated frame.
    tx_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    frame_check("c5_chk", 1'b0, 1'b0);
    check_val("c5_chk_const", 32'(chk_o), 32'd1);

    // CRC-16 over ASCII "123456789".
    sel5 = 1'b0;
    s = "123456789";
    tx_q.delete();
    for (int c = 0; c < s.len(); c++) begin
      logic [7:0] b;
      b = s[c];
      for (int k = 7; k >= 0; k--) tx_q.push_back(b[k]);
    end
    frame_check("c16_gen", 1'b1, 1'b0);
    app = 0;
    for (int i = 72; i < 88 && i < rx_q.size(); i++) app = {app[30:0], 1'(rx_q[i])};
    check_val("c16_app_const", app, 32'hD64E);
    saved_q = rx_q;

    frame_check("c16_gen_bp", 1'b1, 1'b1);
    nbad_out = (rx_q.size() == saved_q.size()) ? 0 : 1;
    for (int i = 0; i < rx_q.size() && i < saved_q.size(); i++)
      if (rx_q[i] != saved_q[i]) nbad_out++;
    check_val("c16_bp_same", nbad_out, 0);

    tx_q = saved_q;
    frame_check("c16_chk", 1'b0, 1'b1);
    check_val("c16_chk_res", crc_o, 32'h1D0F);

    // Random frames on both widths, both modes.
    for (int f = 0; f < 10; f++) begin
      sel5 = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 40);
      tx_q.delete();
      for (int i = 0; i < n; i++) tx_q.push_back(1'($urandom_range(0, 1)));
      if (f % 3 == 2) begin
        // Append a correctly formed CRC so check mode sees a good frame.
        m = ref_crc(tx_q, cur_w(), cur_poly(), cur_preset());
        for (int k = cur_w() - 1; k >= 0; k--) tx_q.push_back(m[k] ^ cur_inv());
        frame_check($sformatf("rnd%0d_good", f), 1'b0, 1'b1);
        check_val($sformatf("rnd%0d_good_chk", f), 32'(chk_o), 32'd1);
      end else begin
        frame_check($sformatf("rnd%0d", f), 1'(f % 2), 1'b1);
      end
    end

    // Abort by start while appending with idx = 7.
    sel5 = 1'b0;
    tx_q.delete();
    for (int i = 0; i < 20; i++) tx_q.push_back(1'($urandom_range(0, 1)));
    do_start(1'b1);
    nobs = 0;
    n = 0;
    while (nobs < 28 && n < 200) begin
      @(negedge clk);
      out_rdy = 1'b1;
      if (n < tx_q.size()) begin
        in_vld = 1'b1; in_dat = tx_q[n]; in_last = (n == tx_q.size() - 1);
      end else begin
        in_vld = 1'b0; in_last = 1'b0;
      end
      #1;
      if (in_vld && in_rdy_o) n++;
      if (out_vld_o && out_rdy) nobs++;
    end
    check_val("abort_reach", nobs, 28);
    in_vld = 1'b0; in_last = 1'b0;
    start = 1'b1; gen = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check_val("abort_busy", 32'(busy_o), 1);
    check_val("abort_rdy", 32'(in_rdy_o), 1);
    check_val("abort_crc", crc_o, 32'hFFFF);
    check_val("abort_vld", 32'(out_vld_o), 0);
    check_val("abort_chkv", 32'(chk_vld_o), 0);
    nbad_out = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_vld_o || out_last_o || chk_vld_o) nbad_out++;
    end
    check_val("abort_quiet", nbad_out, 0);

    // Reset in the middle of a payload.
    do_start(1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_vld = 1'b1; in_dat = 1'($urandom_range(0, 1)); in_last = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("mrst_crc", crc_o, 32'hFFFF);
    check_val("mrst_vld", 32'(out_vld_o), 0);
    check_val("mrst_last", 32'(out_last_o), 0);
    check_val("mrst_dat", 32'(out_dat_o), 0);
    check_val("mrst_chkv", 32'(chk_vld_o), 0);
    check_val("mrst_busy", 32'(busy_o), 0);
    check_val("mrst_rdy", 32'(in_rdy_o), 0);
    @(negedge clk);
    check_val("mrst_rdy2", 32'(in_rdy_o), 0);
    check_val("mrst_crc2", crc_o, 32'hFFFF);
    in_vld = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
